// File: rtl/pipe_reg_pkg.sv
// Shared types for the inter-stage pipeline registers: skid FSM encoding and buffer depth.
package pipe_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b10
    } pipe_state_t;

    localparam int unsigned PIPE_SKID_DEPTH = 2;

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register with a main + skid entry, global stall and masked flush.
// Optional bubble counter enabled by defining PIPE_SKID_REG_BUBBLE_CNT_EN.
module pipe_skid_reg
    import pipe_reg_pkg::*;
#(
    parameter int unsigned          DATA_W   = 16,
    parameter logic [DATA_W-1:0]    CLR_MASK = {DATA_W{1'b1}},
    parameter int unsigned          CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  bubble_cnt
);

    pipe_state_t       state_q, state_d;
    logic [DATA_W-1:0] main_q, main_d;
    logic [DATA_W-1:0] skid_q, skid_d;
    logic              in_fire, out_fire;

    // in_ready depends only on registered occupancy and stall, never on out_ready
    assign in_ready  = (state_q != FULL) & ~stall;
    assign out_valid = (state_q != EMPTY);
    assign out_data  = main_q;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready & ~stall;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
            main_d  = main_q & ~CLR_MASK;
            skid_d  = skid_q & ~CLR_MASK;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

`ifdef PIPE_SKID_REG_BUBBLE_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!out_valid && (cnt_q != '1)) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bubble_cnt = cnt_q;
`else
    assign bubble_cnt = '0;
`endif

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Parametrised successor to the fixed IF/ID pipeline register; the generic inter-stage register for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Replaces the plain write-enable register with a valid/ready handshake and a 2-entry (main + skid) buffer, so upstream ready is never combinationally dependent on downstream ready.
- Keeps global stall/flush semantics; flush zeroes a per-bit, parameter-selected subset of the payload (e.g. instruction word, predicted_taken).

Parameters:
- DATA_W, 16, payload width in bits (>=1).
- CLR_MASK, {DATA_W{1'b1}}, bits set to 1 are forced to 0 on flush; bits set to 0 are retained.
- CNT_W, 16, width of the bubble counter (optional feature).

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  freeze all state; no accept, no release.
- flush  input  1  kill all held entries and apply CLR_MASK; priority over stall.
- in_valid  input  1  upstream payload valid.
- in_data  input  DATA_W  upstream payload.
- in_ready  output  1  block can accept this cycle.
- out_valid  output  1  out_data valid.
- out_data  output  DATA_W  payload to next stage (main entry).
- out_ready  input  1  downstream accepts this cycle.
- bubble_cnt  output  CNT_W  count of cycles with out_valid=0 (optional feature).

Behaviour:
- Reset (async assert, sync release): state EMPTY; main and skid data 0; out_valid 0; out_data 0; bubble_cnt 0. in_ready = 1 once reset deasserts (stall low).
- in_ready = ~skid_full & ~stall (combinational from registers and stall only). out_valid = main_full.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready & ~stall.
- Latency is 1 cycle: data accepted at edge N is on out_data after edge N.
- EMPTY: in_fire -> BUSY, main <= in_data.
- BUSY:
  - in_fire & out_fire -> BUSY, main <= in_data.
  - in_fire & ~out_fire -> FULL, skid <= in_data.
  - ~in_fire & out_fire -> EMPTY.
  - Otherwise hold.
- FULL: in_ready = 0. out_fire -> BUSY, main <= skid. Otherwise hold.
- Ordering is strict FIFO; no payload is dropped or duplicated except by flush.
- Stall (flush low): no state or data change. out_valid and out_data hold; in_ready = 0.
- Flush (any state, any stall): next state EMPTY; main <= main & ~CLR_MASK; skid <= skid & ~CLR_MASK. A same-cycle in_valid payload is discarded, and a same-cycle out_fire still counts as consumed downstream. out_valid = 0 the following cycle.
- Reset mid-operation: immediate clear to reset values regardless of stall or flush.

Optional Feature:
- Macro: PIPE_SKID_REG_BUBBLE_CNT_EN.
- Defined: bubble_cnt increments every cycle out_valid=0 and rst_n=1, saturating at all-ones. Flush and stall do not reset it; only rst_n does.
- Undefined: no counter logic; bubble_cnt tied to 0.

Decomposition:
- Package pipe_reg_pkg: enum pipe_state_t {EMPTY=2'b00, BUSY=2'b01, FULL=2'b10}; constant PIPE_SKID_DEPTH=2.
- No sub-module: storage is two flat registers plus a 2-bit FSM. The saturating counter stays inline.

Test Plan (DATA_W=16, CLR_MASK=16'h00FF unless noted):
- Reset then streaming: in_valid=1, out_ready=1, data 16'h1111, 16'h2222, 16'h3333 on consecutive cycles -> out_data shows the same sequence 1 cycle later; in_ready stays 1; state stays BUSY.
- Backpressure: out_ready=0 while sending 16'hA001, 16'hA002 -> after the 2nd accept in_ready=0 (FULL); 16'hA003 is held off. Raise out_ready -> outputs A001, A002, A003 in order with no loss.
- Stall: in BUSY holding 16'hBEEF, assert stall for 3 cycles with in_valid=1, out_ready=1 -> out_data=16'hBEEF, out_valid=1, in_ready=0 throughout; no fire.
- Flush partial clear: main=16'h12AB, skid=16'h34CD, assert flush with stall=1 and in_valid=1 (16'h5555) -> next cycle out_valid=0, main=16'h1200, skid=16'h3400; 16'h5555 discarded; state EMPTY.
- Async reset mid-FULL: drop rst_n between clock edges -> out_valid=0, out_data=0 immediately; after release, in_ready=1.
- Macro defined, CNT_W=4: hold in_valid=0 for 20 cycles after reset -> bubble_cnt saturates at 4'hF. Macro undefined -> bubble_cnt stays 0.
